// File: rtl/l2_arbiter_if.sv
`default_nettype none
// ============================================================================
//  l2_arbiter_if
//  Cache-line memory port: level-held read/write request with a resp pulse.
//  Revision: 1.0
// ============================================================================
interface l2_arbiter_if;
    logic         read;
    logic         write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic         resp;
    logic [127:0] rdata;

    // The requester side of the port drives the request and receives resp/rdata.
    modport master (
        output read, write, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, address, wdata,
        output resp, rdata
    );
endinterface
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
//  l2_arbiter
//  Round-robin sharing of the single L2 port between the L1 I- and D-caches.
//  Revision: 1.0
// ============================================================================
module l2_arbiter (
    input  wire logic          clk,
    input  wire logic          reset,
    l2_arbiter_if.slave        icache,
    l2_arbiter_if.slave        dcache,
    l2_arbiter_if.master       l2,
    output logic               arb_conflict_inc,
    output logic               arb_stall_inc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;      // 0: I served most recently, 1: D served most recently

    logic   w_i_pend;
    logic   w_d_pend;

    assign w_i_pend = icache.read | icache.write;
    assign w_d_pend = dcache.read | dcache.write;

    assign icache.rdata = l2.rdata;
    assign dcache.rdata = l2.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_pend && w_d_pend)
                        r_state <= r_last ? SERVE_I : SERVE_D;
                    else if (w_i_pend)
                        r_state <= SERVE_I;
                    else if (w_d_pend)
                        r_state <= SERVE_D;
                end
                SERVE_I: begin
                    if (l2.resp) begin
                        r_state <= IDLE;
                        r_last  <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (l2.resp) begin
                        r_state <= IDLE;
                        r_last  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an aborted grant is invisible in the reset cycle.
    always_comb begin
        l2.read          = 1'b0;
        l2.write         = 1'b0;
        l2.address       = '0;
        l2.wdata         = '0;
        icache.resp      = 1'b0;
        dcache.resp      = 1'b0;
        arb_conflict_inc = 1'b0;
        arb_stall_inc    = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    arb_conflict_inc = w_i_pend & w_d_pend;
                end
                SERVE_I: begin
                    l2.read       = icache.read;
                    l2.write      = icache.write;
                    l2.address    = icache.address;
                    l2.wdata      = icache.wdata;
                    icache.resp   = l2.resp;
                    arb_stall_inc = w_d_pend;
                end
                SERVE_D: begin
                    l2.read       = dcache.read;
                    l2.write      = dcache.write;
                    l2.address    = dcache.address;
                    l2.wdata      = dcache.wdata;
                    dcache.resp   = l2.resp;
                    arb_stall_inc = w_i_pend;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_l2_arbiter
//  Directed scenarios followed by random traffic, checked against a reference model.
//  Revision: 1.0
// ============================================================================
module tb_l2_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic arb_conflict_inc;
    logic arb_stall_inc;

    l2_arbiter_if icache_bus ();
    l2_arbiter_if dcache_bus ();
    l2_arbiter_if l2_bus ();

    l2_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .icache           (icache_bus),
        .dcache           (dcache_bus),
        .l2               (l2_bus),
        .arb_conflict_inc (arb_conflict_inc),
        .arb_stall_inc    (arb_stall_inc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the L2 port (0 none, 1 I, 2 D) and who wins the next tie.
    int m_owner;
    bit m_d_wins_tie;
    bit m_exp_i_resp;
    bit m_exp_d_resp;

    logic         s_l2_read, s_l2_write, s_i_resp, s_d_resp, s_conf, s_stall;
    logic [15:0]  s_addr;
    logic [127:0] s_wdata, s_i_rdata, s_d_rdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic ip, dp;
        logic e_rd, e_wr, e_ir, e_dr, e_cf, e_st;
        logic [15:0]  e_a;
        logic [127:0] e_wd;
        ip = icache_bus.read | icache_bus.write;
        dp = dcache_bus.read | dcache_bus.write;
        {e_rd, e_wr, e_ir, e_dr, e_cf, e_st} = '0;
        e_a  = '0;
        e_wd = '0;
        if (!reset) begin
            if (m_owner == 0) begin
                e_cf = ip & dp;
            end else if (m_owner == 1) begin
                e_rd = icache_bus.read;  e_wr = icache_bus.write;
                e_a  = icache_bus.address; e_wd = icache_bus.wdata;
                e_ir = l2_bus.resp;      e_st = dp;
            end else begin
                e_rd = dcache_bus.read;  e_wr = dcache_bus.write;
                e_a  = dcache_bus.address; e_wd = dcache_bus.wdata;
                e_dr = l2_bus.resp;      e_st = ip;
            end
        end
        m_exp_i_resp = e_ir;
        m_exp_d_resp = e_dr;
        s_l2_read = l2_bus.read;   s_l2_write = l2_bus.write;
        s_addr    = l2_bus.address; s_wdata   = l2_bus.wdata;
        s_i_resp  = icache_bus.resp; s_d_resp = dcache_bus.resp;
        s_i_rdata = icache_bus.rdata; s_d_rdata = dcache_bus.rdata;
        s_conf    = arb_conflict_inc; s_stall = arb_stall_inc;
        chk("l2_read",  {127'd0, s_l2_read},  {127'd0, e_rd});
        chk("l2_write", {127'd0, s_l2_write}, {127'd0, e_wr});
        chk("l2_address", {112'd0, s_addr},   {112'd0, e_a});
        chk("l2_wdata", s_wdata, e_wd);
        chk("icache_resp", {127'd0, s_i_resp}, {127'd0, e_ir});
        chk("dcache_resp", {127'd0, s_d_resp}, {127'd0, e_dr});
        chk("icache_rdata", s_i_rdata, l2_bus.rdata);
        chk("dcache_rdata", s_d_rdata, l2_bus.rdata);
        chk("conflict_inc", {127'd0, s_conf},  {127'd0, e_cf});
        chk("stall_inc",    {127'd0, s_stall}, {127'd0, e_st});
    endtask

    task automatic model_update(input logic ip, input logic dp, input logic rst, input logic rsp);
        if (rst) begin
            m_owner      = 0;
            m_d_wins_tie = 1'b1;
        end else if (m_owner == 0) begin
            if (ip && dp)  m_owner = m_d_wins_tie ? 2 : 1;
            else if (ip)   m_owner = 1;
            else if (dp)   m_owner = 2;
        end else if (rsp) begin
            m_d_wins_tie = (m_owner == 1);
            m_owner      = 0;
        end
    endtask

    // One clock: check outputs mid-cycle, step the model on the edge, return at the negedge.
    task automatic cyc();
        logic ip, dp, rst, rsp;
        #1;
        model_check();
        ip  = icache_bus.read | icache_bus.write;
        dp  = dcache_bus.read | dcache_bus.write;
        rst = reset;
        rsp = l2_bus.resp;
        @(posedge clk);
        model_update(ip, dp, rst, rsp);
        @(negedge clk);
    endtask

    task automatic drive_i(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        icache_bus.read = rd; icache_bus.write = wr; icache_bus.address = a; icache_bus.wdata = d;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        dcache_bus.read = rd; dcache_bus.write = wr; dcache_bus.address = a; dcache_bus.wdata = d;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] line;
        logic [15:0]  order [4];
        int           stalls;

        order[0] = 16'h8000; order[1] = 16'h0040; order[2] = 16'h8000; order[3] = 16'h0040;
        m_owner = 0;
        m_d_wins_tie = 1'b1;
        reset = 1'b1;
        drive_i(0, 0, 16'h0, '0);
        drive_d(0, 0, 16'h0, '0);
        l2_bus.resp  = 1'b0;
        l2_bus.rdata = '0;
        @(negedge clk);

        // Reset: everything quiet, even with a stray l2_resp
        cyc();
        l2_bus.resp = 1'b1;
        cyc();
        chk("rst_l2_read", {127'd0, s_l2_read}, 128'd0);
        chk("rst_i_resp",  {127'd0, s_i_resp},  128'd0);
        l2_bus.resp = 1'b0;
        reset = 1'b0;

        // Lone I read of 0x1230
        drive_i(1, 0, 16'h1230, '0);
        cyc();
        chk("i_grant_latency", {127'd0, s_l2_read}, 128'd0);
        cyc();
        chk("i_l2_read", {127'd0, s_l2_read}, 128'd1);
        chk("i_l2_addr", {112'd0, s_addr}, {112'd0, 16'h1230});
        cyc();
        cyc();
        line = rand_line();
        l2_bus.resp = 1'b1; l2_bus.rdata = line;
        cyc();
        chk("i_resp_pulse", {127'd0, s_i_resp}, 128'd1);
        chk("i_rdata", s_i_rdata, line);
        chk("i_d_resp_quiet", {127'd0, s_d_resp}, 128'd0);
        l2_bus.resp = 1'b0;
        drive_i(0, 0, 16'h0, '0);
        cyc();

        // Conflict in first IDLE after reset: D first
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive_i(1, 0, 16'h0040, '0);
        drive_d(1, 0, 16'h8000, '0);
        cyc();
        chk("c_conflict", {127'd0, s_conf}, 128'd1);
        cyc();
        chk("c_d_first", {112'd0, s_addr}, {112'd0, 16'h8000});
        chk("c_stall", {127'd0, s_stall}, 128'd1);
        l2_bus.resp = 1'b1;
        cyc();
        chk("c_d_resp", {127'd0, s_d_resp}, 128'd1);
        l2_bus.resp = 1'b0;
        drive_d(0, 0, 16'h0, '0);
        cyc();
        chk("c_turnaround", {127'd0, s_l2_read}, 128'd0);
        cyc();
        chk("c_i_second", {112'd0, s_addr}, {112'd0, 16'h0040});
        l2_bus.resp = 1'b1;
        cyc();
        l2_bus.resp = 1'b0;

        // Both continuously requesting: D, I, D, I with one IDLE between
        drive_d(1, 0, 16'h8000, '0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_idle_gap", {127'd0, s_l2_read}, 128'd0);
            cyc();
            chk("rr_order", {112'd0, s_addr}, {112'd0, order[k]});
            l2_bus.resp = 1'b1;
            cyc();
            l2_bus.resp = 1'b0;
        end
        drive_i(0, 0, 16'h0, '0);
        drive_d(0, 0, 16'h0, '0);
        cyc();

        // D write
        drive_d(0, 1, 16'h2000, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
        cyc();
        cyc();
        chk("w_l2_write", {127'd0, s_l2_write}, 128'd1);
        chk("w_l2_wdata", s_wdata, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
        l2_bus.resp = 1'b1;
        cyc();
        chk("w_d_resp", {127'd0, s_d_resp}, 128'd1);
        chk("w_i_resp", {127'd0, s_i_resp}, 128'd0);
        l2_bus.resp = 1'b0;
        drive_d(0, 0, 16'h0, '0);
        cyc();

        // Reset in SERVE_D, late l2_resp ignored, next conflict goes to D
        drive_d(1, 0, 16'h8000, '0);
        cyc();
        cyc();
        chk("r_serve_d", {112'd0, s_addr}, {112'd0, 16'h8000});
        reset = 1'b1;
        drive_d(0, 0, 16'h0, '0);
        cyc();
        chk("r_abort_read", {127'd0, s_l2_read}, 128'd0);
        reset = 1'b0;
        cyc();
        l2_bus.resp = 1'b1;
        cyc();
        chk("r_late_d_resp", {127'd0, s_d_resp}, 128'd0);
        chk("r_late_i_resp", {127'd0, s_i_resp}, 128'd0);
        l2_bus.resp = 1'b0;
        drive_i(1, 0, 16'h0040, '0);
        drive_d(1, 0, 16'h8000, '0);
        cyc();
        cyc();
        chk("r_next_conflict_d", {112'd0, s_addr}, {112'd0, 16'h8000});
        l2_bus.resp = 1'b1;
        cyc();
        l2_bus.resp = 1'b0;
        drive_i(0, 0, 16'h0, '0);
        drive_d(0, 0, 16'h0, '0);
        cyc();

        // I waits behind a 10-cycle D transaction
        drive_d(1, 0, 16'h8000, '0);
        cyc();
        drive_i(1, 0, 16'h0040, '0);
        stalls = 0;
        for (int k = 0; k < 10; k++) begin
            l2_bus.resp = (k == 9);
            cyc();
            if (s_stall === 1'b1) stalls++;
        end
        chk("s_stall_cycles", 128'(stalls), 128'd10);
        l2_bus.resp = 1'b0;
        drive_d(0, 0, 16'h0, '0);
        cyc();
        chk("s_turnaround", {127'd0, s_l2_read}, 128'd0);
        cyc();
        chk("s_i_granted", {112'd0, s_addr}, {112'd0, 16'h0040});
        l2_bus.resp = 1'b1;
        cyc();
        l2_bus.resp = 1'b0;
        drive_i(0, 0, 16'h0, '0);
        cyc();

        // Random traffic: L1s hold requests until their resp, L2 responds at random
        for (int n = 0; n < 3000; n++) begin
            logic rd;
            reset = ($urandom_range(0, 99) == 0);
            if ((icache_bus.read | icache_bus.write) && (m_exp_i_resp || reset))
                drive_i(0, 0, 16'h0, '0);
            else if (!(icache_bus.read | icache_bus.write) && $urandom_range(0, 9) < 4) begin
                rd = $urandom_range(0, 1);
                drive_i(rd, ~rd, 16'($urandom), rand_line());
            end
            if ((dcache_bus.read | dcache_bus.write) && (m_exp_d_resp || reset))
                drive_d(0, 0, 16'h0, '0);
            else if (!(dcache_bus.read | dcache_bus.write) && $urandom_range(0, 9) < 4) begin
                rd = $urandom_range(0, 1);
                drive_d(rd, ~rd, 16'($urandom), rand_line());
            end
            l2_bus.resp  = ($urandom_range(0, 2) == 0);
            l2_bus.rdata = rand_line();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
